// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-unit bus bundle (PC, program memory, decoder, control)
//   master: the fetch sequencer; slave: the surrounding PC/memory/decoder
//   FETCH_EN, PC_ADDR, MEM_RDY, MEM_DATA, DEC_ACK, FLUSH  -> into the sequencer
//   I_PC, MEM_RD, MEM_ADDR, IR, OR, IR_VALID, FETCH_ERR     <- out of the sequencer
interface instruction_fetch_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          FETCH_EN;
  logic [AW-1:0] PC_ADDR;
  logic          I_PC;
  logic          MEM_RD;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RDY;
  logic [DW-1:0] MEM_DATA;
  logic [DW-1:0] IR;
  logic [DW-1:0] OR;
  logic          IR_VALID;
  logic          DEC_ACK;
  logic          FLUSH;
  logic          FETCH_ERR;
  modport master (
    input  FETCH_EN, PC_ADDR, MEM_RDY, MEM_DATA, DEC_ACK, FLUSH,
    output I_PC, MEM_RD, MEM_ADDR, IR, OR, IR_VALID, FETCH_ERR
  );
  modport slave (
    output FETCH_EN, PC_ADDR, MEM_RDY, MEM_DATA, DEC_ACK, FLUSH,
    input  I_PC, MEM_RD, MEM_ADDR, IR, OR, IR_VALID, FETCH_ERR
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: opcode/operand fetch sequencer between the PC and program memory
//   CLK, RST      clock and asynchronous active-high reset
//   bus (master)  FETCH_EN/PC_ADDR/I_PC to and from the PC, MEM_RD/MEM_ADDR/MEM_RDY/MEM_DATA
//                 to program memory, IR/OR/IR_VALID/DEC_ACK to the decoder, FLUSH abort, FETCH_ERR
module instruction_fetch #(
  parameter int            DW            = 8,
  parameter int            AW            = 8,
  parameter logic [DW-1:0] TWO_BYTE_MASK = 8'h80,
  parameter int            TIMEOUT       = 15
) (
  input logic                  CLK,
  input logic                  RST,
  instruction_fetch_if.master  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD_OP, INC_OP, RD_OPD, INC_OPD, HOLD, ERR} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d, or_q, or_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          rd, inc, timed_out;
  always_comb begin
    rd        = (state_q == RD_OP) || (state_q == RD_OPD);
    inc       = (state_q == INC_OP) || (state_q == INC_OPD);
    timed_out = cnt_q == CW'(TIMEOUT);
    state_d   = state_q;
    ir_d      = ir_q;
    or_d      = or_q;
    case (state_q)
      IDLE:    state_d = bus.FETCH_EN ? RD_OP : IDLE;
      RD_OP:   begin
        ir_d    = bus.MEM_RDY ? bus.MEM_DATA : ir_q;
        state_d = bus.MEM_RDY ? INC_OP : (timed_out ? ERR : RD_OP);
      end
      INC_OP:  state_d = |(ir_q & TWO_BYTE_MASK) ? RD_OPD : HOLD;
      RD_OPD:  begin
        or_d    = bus.MEM_RDY ? bus.MEM_DATA : or_q;
        state_d = bus.MEM_RDY ? INC_OPD : (timed_out ? ERR : RD_OPD);
      end
      INC_OPD: state_d = HOLD;
      HOLD:    state_d = bus.DEC_ACK ? (bus.FETCH_EN ? RD_OP : IDLE) : HOLD;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    // an abort wins over everything and must not disturb the latched bytes
    if (bus.FLUSH) begin
      state_d = IDLE;
      ir_d    = ir_q;
      or_d    = or_q;
    end
    // counts wait cycles only while a read stays put; any exit or re-entry starts from zero
    cnt_d   = (rd && state_d == state_q) ? cnt_q + 1'b1 : '0;
    valid_d = state_d == HOLD;
    err_d   = state_d == ERR;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ir_q    <= '0;
      or_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      or_q    <= or_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    bus.MEM_RD    = rd;
    bus.MEM_ADDR  = rd ? bus.PC_ADDR : '0;
    // gated by FLUSH so the PC never sees an increment alongside its own reload
    bus.I_PC      = inc && !bus.FLUSH;
    bus.IR        = ir_q;
    bus.OR        = or_q;
    bus.IR_VALID  = valid_q;
    bus.FETCH_ERR = err_q;
  end
endmodule
